// File: rtl/hpdcache_pkg.sv
// Shared types for the HPDcache replacement path: set/way vectors and the
// replacement-sequencer FSM states.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_SETS  = 64;
    localparam int unsigned HPDCACHE_WAYS  = 4;
    localparam int unsigned HPDCACHE_SET_W = $clog2(HPDCACHE_SETS);

    typedef logic [HPDCACHE_SET_W-1:0] hpdcache_set_t;
    typedef logic [HPDCACHE_WAYS-1:0]  hpdcache_way_vector_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIR_WAIT = 2'd1,
        SELECT   = 2'd2,
        RESP     = 2'd3
    } hpdcache_repl_state_e;

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Priority encoder: keeps only the lowest set bit of the input vector.
module hpdcache_prio_1hot_encoder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] val_i,
    output logic [N-1:0] val_o
);

    // Two's-complement trick isolates the least-significant one.
    assign val_o = val_i & (~val_i + N'(1));

endmodule

// File: rtl/hpdcache_repl_pend_tbl.sv
// In-flight refill table: one entry per outstanding allocation, looked up by
// set so the same set is never allocated twice concurrently.
module hpdcache_repl_pend_tbl
    import hpdcache_pkg::*;
#(
    parameter int unsigned NPEND = 4,
    parameter int unsigned SET_W = 6,
    parameter int unsigned ID_W  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_i,
    input  logic [SET_W-1:0] alloc_set_i,
    input  logic             release_i,
    input  logic [ID_W-1:0]  release_id_i,
    input  logic [SET_W-1:0] lookup_set_i,
    output logic             hit_o,
    output logic             full_o,
    output logic [ID_W-1:0]  free_id_o
);

    logic [NPEND-1:0] valid_q, valid_d;
    logic [SET_W-1:0] set_q [NPEND];
    logic [NPEND-1:0] free_1hot;

    hpdcache_prio_1hot_encoder #(
        .N(NPEND)
    ) i_free_enc (
        .val_i(~valid_q),
        .val_o(free_1hot)
    );

    always_comb begin
        hit_o     = 1'b0;
        free_id_o = '0;
        for (int i = 0; i < int'(NPEND); i++) begin
            if (valid_q[i] && (set_q[i] == lookup_set_i)) hit_o = 1'b1;
            if (free_1hot[i]) free_id_o = ID_W'(i);
        end
    end

    assign full_o = &valid_q;

    // Release is applied before allocate; a release aimed at an invalid
    // entry clears nothing, so it can never cancel the new allocation.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < int'(NPEND); i++) begin
            if (release_i && (release_id_i == ID_W'(i))) valid_d[i] = 1'b0;
            if (alloc_i && free_1hot[i]) valid_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NPEND); i++) begin
            if (alloc_i && free_1hot[i]) set_q[i] <= alloc_set_i;
        end
    end

endmodule

// File: rtl/hpdcache_repl_ctrl.sv
// Replacement sequencer: reads directory valid bits, fires one repl pulse to
// victim selection and returns set/way/evict/id to the miss handler.
module hpdcache_repl_ctrl
    import hpdcache_pkg::*;
#(
    parameter  int unsigned SETS       = HPDCACHE_SETS,
    parameter  int unsigned WAYS       = HPDCACHE_WAYS,
    parameter  int unsigned DIR_RD_LAT = 1,
    parameter  int unsigned NPEND      = 4,
    localparam int unsigned SET_W      = $clog2(SETS),
    localparam int unsigned ID_W       = (NPEND > 1) ? $clog2(NPEND) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [SET_W-1:0] req_set_i,
    input  logic             req_updt_plru_i,
    output logic             dir_rd_o,
    output logic [SET_W-1:0] dir_set_o,
    input  logic [WAYS-1:0]  dir_valid_i,
    output logic             repl_o,
    output logic [SET_W-1:0] repl_set_o,
    output logic [WAYS-1:0]  repl_dir_valid_o,
    output logic             repl_updt_o,
    input  logic [WAYS-1:0]  victim_way_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [SET_W-1:0] rsp_set_o,
    output logic [WAYS-1:0]  rsp_way_o,
    output logic             rsp_evict_o,
    output logic [ID_W-1:0]  rsp_id_o,
    input  logic             done_i,
    input  logic [ID_W-1:0]  done_id_i
);

    localparam int unsigned CNT_W = 2;

    hpdcache_repl_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SET_W-1:0] set_q, set_d;
    logic             updt_q, updt_d;
    logic [WAYS-1:0]  dvalid_q, dvalid_d;
    logic [WAYS-1:0]  way_q, way_d;
    logic             evict_q, evict_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic             tbl_hit, tbl_full, tbl_alloc;
    logic [ID_W-1:0]  tbl_free_id;

    hpdcache_repl_pend_tbl #(
        .NPEND(NPEND),
        .SET_W(SET_W),
        .ID_W (ID_W)
    ) i_pend_tbl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alloc_i     (tbl_alloc),
        .alloc_set_i (set_q),
        .release_i   (done_i),
        .release_id_i(done_id_i),
        .lookup_set_i(req_set_i),
        .hit_o       (tbl_hit),
        .full_o      (tbl_full),
        .free_id_o   (tbl_free_id)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        set_d            = set_q;
        updt_d           = updt_q;
        dvalid_d         = dvalid_q;
        way_d            = way_q;
        evict_d          = evict_q;
        id_d             = id_q;
        tbl_alloc        = 1'b0;
        req_ready_o      = 1'b0;
        dir_rd_o         = 1'b0;
        dir_set_o        = '0;
        repl_o           = 1'b0;
        repl_set_o       = '0;
        repl_dir_valid_o = '0;
        repl_updt_o      = 1'b0;
        rsp_valid_o      = 1'b0;
        rsp_set_o        = '0;
        rsp_way_o        = '0;
        rsp_evict_o      = 1'b0;
        rsp_id_o         = '0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = ~tbl_full & ~tbl_hit;
                if (req_valid_i && req_ready_o) begin
                    set_d     = req_set_i;
                    updt_d    = req_updt_plru_i;
                    dir_rd_o  = 1'b1;
                    dir_set_o = req_set_i;
                    cnt_d     = '0;
                    state_d   = DIR_WAIT;
                end
            end
            DIR_WAIT: begin
                dir_set_o = set_q;
                if (cnt_q == CNT_W'(DIR_RD_LAT - 1)) begin
                    dvalid_d = dir_valid_i;
                    state_d  = SELECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SELECT: begin
                repl_o           = 1'b1;
                repl_set_o       = set_q;
                repl_dir_valid_o = dvalid_q;
                repl_updt_o      = updt_q;
                way_d            = victim_way_i;
                evict_d          = |(victim_way_i & dvalid_q);
                id_d             = tbl_free_id;
                tbl_alloc        = 1'b1;
                state_d          = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                rsp_set_o   = set_q;
                rsp_way_o   = way_q;
                rsp_evict_o = evict_q;
                rsp_id_o    = id_q;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        set_q    <= set_d;
        updt_q   <= updt_d;
        dvalid_q <= dvalid_d;
        way_q    <= way_d;
        evict_q  <= evict_d;
        id_q     <= id_d;
    end

    a_victim_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == SELECT) |-> $onehot(victim_way_i));

endmodule

// File: tb/tb_hpdcache_repl_ctrl.sv
// Bench for hpdcache_repl_ctrl: directed vector table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_hpdcache_repl_ctrl;

    localparam int LAT = 1;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       req_valid_i, req_ready_o, req_updt_plru_i;
    logic [5:0] req_set_i;
    logic       dir_rd_o;
    logic [5:0] dir_set_o;
    logic [3:0] dir_valid_i;
    logic       repl_o, repl_updt_o;
    logic [5:0] repl_set_o;
    logic [3:0] repl_dir_valid_o, victim_way_i;
    logic       rsp_valid_o, rsp_ready_i, rsp_evict_o;
    logic [5:0] rsp_set_o;
    logic [3:0] rsp_way_o;
    logic [1:0] rsp_id_o, done_id_i;
    logic       done_i;

    always #5 clk_i = ~clk_i;

    hpdcache_repl_ctrl #(.DIR_RD_LAT(LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_set_i(req_set_i), .req_updt_plru_i(req_updt_plru_i),
        .dir_rd_o(dir_rd_o), .dir_set_o(dir_set_o), .dir_valid_i(dir_valid_i),
        .repl_o(repl_o), .repl_set_o(repl_set_o),
        .repl_dir_valid_o(repl_dir_valid_o), .repl_updt_o(repl_updt_o),
        .victim_way_i(victim_way_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_set_o(rsp_set_o), .rsp_way_o(rsp_way_o),
        .rsp_evict_o(rsp_evict_o), .rsp_id_o(rsp_id_o),
        .done_i(done_i), .done_id_i(done_id_i)
    );

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read 3 later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        req_valid_i = 1'b0; req_set_i = '0; req_updt_plru_i = 1'b0;
        dir_valid_i = '0; victim_way_i = 4'b0001; rsp_ready_i = 1'b0;
        done_i = 1'b0; done_id_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle_inputs();
        step();
        rst_i = 1'b0;
    endtask

    // Full transaction with LAT-cycle directory wait; returns id and stall count.
    task automatic txn(input logic [5:0] s, input logic [3:0] dv, input logic [3:0] vic,
                       output int id, output int waited);
        req_valid_i = 1'b1; req_set_i = s; waited = 0; id = -1;
        settle();
        while (!req_ready_o && waited < 40) begin
            step(); waited++; settle();
        end
        if (!req_ready_o) begin
            chk("txn_accept_timeout", 0, 1);
            req_valid_i = 1'b0;
            return;
        end
        step();
        req_valid_i = 1'b0; dir_valid_i = dv;
        for (int k = 1; k < LAT; k++) step();
        step();
        dir_valid_i = '0; victim_way_i = vic;
        settle();
        chk("txn_repl", int'(repl_o), 1);
        chk("txn_repl_set", int'(repl_set_o), int'(s));
        step();
        victim_way_i = 4'b0001; rsp_ready_i = 1'b1;
        settle();
        chk("txn_rsp_valid", int'(rsp_valid_o), 1);
        chk("txn_rsp_way", int'(rsp_way_o), int'(vic));
        chk("txn_rsp_evict", int'(rsp_evict_o), int'(|(vic & dv)));
        id = int'(rsp_id_o);
        step();
        rsp_ready_i = 1'b0;
    endtask

    typedef struct {
        logic       rv;   logic [5:0] set; logic [3:0] dv;  logic [3:0] vic;
        logic       rr;   logic       dn;  logic [1:0] did;
        logic       e_rdy; logic      e_dr; logic      e_repl; logic e_rsp;
        logic [3:0] e_way; logic      e_ev; logic [1:0] e_id;
    } vec_t;

    function automatic vec_t mkv(input logic rv, input logic [5:0] set, input logic [3:0] dv,
                                 input logic [3:0] vic, input logic rr, input logic dn,
                                 input logic [1:0] did, input logic er, input logic ed,
                                 input logic ep, input logic es, input logic [3:0] ew,
                                 input logic ee, input logic [1:0] ei);
        vec_t v;
        v.rv = rv; v.set = set; v.dv = dv; v.vic = vic; v.rr = rr; v.dn = dn; v.did = did;
        v.e_rdy = er; v.e_dr = ed; v.e_repl = ep; v.e_rsp = es;
        v.e_way = ew; v.e_ev = ee; v.e_id = ei;
        return v;
    endfunction

    vec_t tbl [10];

    // Reference model state: in-flight entries as a queue of {id, set}.
    typedef struct { int id; int set; } pend_t;
    pend_t pend [$];

    function automatic bit pend_has_set(input int s);
        foreach (pend[i]) if (pend[i].set == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pend_has_id(input int id);
        foreach (pend[i]) if (pend[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < 4; i++) if (!pend_has_id(i)) return i;
        return -1;
    endfunction

    initial begin
        int id, w;
        logic [5:0] h_set; logic [3:0] h_way; logic h_ev; logic [1:0] h_id;
        int age, m_set, m_id, m_ev; logic [3:0] m_dv, m_way;
        bit e_rdy, alloc;

        // Reset state
        do_reset();
        settle();
        chk("rst_ready", int'(req_ready_o), 1);
        chk("rst_rsp_valid", int'(rsp_valid_o), 0);
        chk("rst_repl", int'(repl_o), 0);
        chk("rst_dir_rd", int'(dir_rd_o), 0);

        // Scenarios 1 and 2 as a cycle-by-cycle vector table
        tbl[0] = mkv(1'b1, 6'd5, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
        tbl[1] = mkv(1'b0, 6'd5, 4'b0111, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
        tbl[2] = mkv(1'b0, 6'd5, 4'b0000, 4'b1000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        tbl[3] = mkv(1'b0, 6'd5, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd0);
        tbl[4] = mkv(1'b0, 6'd7, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
        tbl[5] = mkv(1'b1, 6'd9, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
        tbl[6] = mkv(1'b0, 6'd9, 4'b1111, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
        tbl[7] = mkv(1'b0, 6'd9, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        tbl[8] = mkv(1'b0, 6'd9, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd0);
        tbl[9] = mkv(1'b0, 6'd9, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            req_valid_i = tbl[i].rv; req_set_i = tbl[i].set; dir_valid_i = tbl[i].dv;
            victim_way_i = tbl[i].vic; rsp_ready_i = tbl[i].rr;
            done_i = tbl[i].dn; done_id_i = tbl[i].did;
            settle();
            chk($sformatf("vec%0d_ready", i), int'(req_ready_o), int'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_dir_rd", i), int'(dir_rd_o), int'(tbl[i].e_dr));
            chk($sformatf("vec%0d_repl", i), int'(repl_o), int'(tbl[i].e_repl));
            chk($sformatf("vec%0d_rsp_valid", i), int'(rsp_valid_o), int'(tbl[i].e_rsp));
            if (tbl[i].e_repl) chk($sformatf("vec%0d_repl_set", i), int'(repl_set_o), int'(tbl[i].set));
            if (tbl[i].e_rsp) begin
                chk($sformatf("vec%0d_rsp_set", i), int'(rsp_set_o), int'(tbl[i].set));
                chk($sformatf("vec%0d_rsp_way", i), int'(rsp_way_o), int'(tbl[i].e_way));
                chk($sformatf("vec%0d_rsp_evict", i), int'(rsp_evict_o), int'(tbl[i].e_ev));
                chk($sformatf("vec%0d_rsp_id", i), int'(rsp_id_o), int'(tbl[i].e_id));
            end
        end
        step();
        idle_inputs();

        // Set conflict held until release; accepted the cycle after done_i
        do_reset();
        txn(6'd5, 4'b0000, 4'b0001, id, w);
        chk("t3_first_id", id, 0);
        req_valid_i = 1'b1; req_set_i = 6'd5;
        for (int k = 0; k < 3; k++) begin
            settle(); chk("t3_conflict_ready", int'(req_ready_o), 0); step();
        end
        done_i = 1'b1; done_id_i = 2'd0;
        settle();
        chk("t3_ready_same_cycle_as_done", int'(req_ready_o), 0);
        step();
        done_i = 1'b0;
        txn(6'd5, 4'b0000, 4'b0001, id, w);
        chk("t3_accept_wait", w, 0);
        chk("t3_second_id", id, 0);

        // Table full: fifth request stalls until entry 2 is released
        do_reset();
        for (int s = 1; s <= 4; s++) begin
            txn(6'(s), 4'b0000, 4'b0001, id, w);
            chk("t4_fill_id", id, s - 1);
        end
        req_valid_i = 1'b1; req_set_i = 6'd6;
        for (int k = 0; k < 3; k++) begin
            settle(); chk("t4_full_ready", int'(req_ready_o), 0); step();
        end
        done_i = 1'b1; done_id_i = 2'd2;
        step();
        done_i = 1'b0;
        txn(6'd6, 4'b1111, 4'b0100, id, w);
        chk("t4_freed_id", id, 2);
        chk("t4_accept_wait", w, 0);

        // Response back-pressure: fields held stable, no second repl pulse
        do_reset();
        req_valid_i = 1'b1; req_set_i = 6'd3;
        settle();
        chk("t5_accept_ready", int'(req_ready_o), 1);
        step();
        req_valid_i = 1'b0; dir_valid_i = 4'b0011;
        step();
        dir_valid_i = '0; victim_way_i = 4'b0001;
        step();
        settle();
        chk("t5_rsp_valid", int'(rsp_valid_o), 1);
        chk("t5_rsp_evict", int'(rsp_evict_o), 1);
        h_set = rsp_set_o; h_way = rsp_way_o; h_ev = rsp_evict_o; h_id = rsp_id_o;
        for (int k = 0; k < 5; k++) begin
            step(); settle();
            chk("t5_hold_valid", int'(rsp_valid_o), 1);
            chk("t5_hold_set", int'(rsp_set_o), int'(h_set));
            chk("t5_hold_way", int'(rsp_way_o), int'(h_way));
            chk("t5_hold_evict", int'(rsp_evict_o), int'(h_ev));
            chk("t5_hold_id", int'(rsp_id_o), int'(h_id));
            chk("t5_no_repl", int'(repl_o), 0);
        end
        chk("t5_set", int'(h_set), 3);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        settle();
        chk("t5_released", int'(rsp_valid_o), 0);

        // Reset during DIR_WAIT
        do_reset();
        req_valid_i = 1'b1; req_set_i = 6'd8;
        step();
        req_valid_i = 1'b0; rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        settle();
        chk("t6_rsp_valid", int'(rsp_valid_o), 0);
        chk("t6_ready", int'(req_ready_o), 1);
        for (int k = 0; k < 4; k++) begin
            step(); settle();
            chk("t6_no_repl", int'(repl_o), 0);
            chk("t6_no_rsp", int'(rsp_valid_o), 0);
        end

        // Randomized run against the transaction-level model
        do_reset();
        pend.delete();
        age = -1; m_set = 0; m_id = 0; m_ev = 0; m_dv = '0; m_way = '0;
        for (int c = 0; c < 3000; c++) begin
            step();
            req_valid_i     = ($urandom_range(0, 2) != 0);
            req_set_i       = 6'($urandom_range(0, 5));
            req_updt_plru_i = 1'($urandom_range(0, 1));
            dir_valid_i     = 4'($urandom_range(0, 15));
            victim_way_i    = 4'(1 << $urandom_range(0, 3));
            rsp_ready_i     = ($urandom_range(0, 3) != 0);
            done_i          = ($urandom_range(0, 5) == 0);
            if (pend.size() > 0 && $urandom_range(0, 3) != 0)
                done_id_i = 2'(pend[$urandom_range(0, pend.size() - 1)].id);
            else
                done_id_i = 2'($urandom_range(0, 3));
            settle();

            e_rdy = (age < 0) && (pend.size() < 4) && !pend_has_set(int'(req_set_i));
            chk("rnd_ready", int'(req_ready_o), int'(e_rdy));
            chk("rnd_dir_rd", int'(dir_rd_o), int'(e_rdy && req_valid_i));
            chk("rnd_repl", int'(repl_o), int'(age == LAT + 1));
            if (age == LAT + 1) chk("rnd_repl_set", int'(repl_set_o), m_set);
            chk("rnd_rsp_valid", int'(rsp_valid_o), int'(age == LAT + 2));
            if (age == LAT + 2) begin
                chk("rnd_rsp_set", int'(rsp_set_o), m_set);
                chk("rnd_rsp_way", int'(rsp_way_o), int'(m_way));
                chk("rnd_rsp_evict", int'(rsp_evict_o), m_ev);
                chk("rnd_rsp_id", int'(rsp_id_o), m_id);
            end

            alloc = 1'b0;
            if (age < 0) begin
                if (req_valid_i && e_rdy) begin
                    m_set = int'(req_set_i); age = 1;
                end
            end else if (age <= LAT) begin
                if (age == LAT) m_dv = dir_valid_i;
                age++;
            end else if (age == LAT + 1) begin
                m_way = victim_way_i;
                m_ev  = int'(|(victim_way_i & m_dv));
                m_id  = lowest_free();
                alloc = 1'b1;
                age++;
            end else if (rsp_ready_i) begin
                age = -1;
            end
            if (done_i) begin
                for (int i = 0; i < pend.size(); i++)
                    if (pend[i].id == int'(done_id_i)) begin pend.delete(i); break; end
            end
            if (alloc) pend.push_back('{id: m_id, set: m_set});
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
